// File: rtl/main_gate.sv
// Disaster-relief request dispatcher: an Evac FIFO plus aging Shelter/Food priority queues,
// with a combinational selector presenting one head request that Serve retires.

module main_gate_pq #(
  parameter int DEPTH   = 4,
  parameter int AGE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serve_win,
  input  logic       cancel,
  input  logic [7:0] cancel_zone,
  input  logic       push,
  input  logic [7:0] push_zone,
  input  logic [1:0] push_prio,
  output logic       valid,
  output logic       full,
  output logic [7:0] win_zone,
  output logic [1:0] win_eff,
  output logic       win_boost
);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          ent_valid [DEPTH];
  logic [7:0]    ent_zone  [DEPTH];
  logic [1:0]    ent_prio  [DEPTH];
  logic [AW-1:0] ent_age   [DEPTH];
  logic          ent_boost [DEPTH];
  logic [1:0]    ent_eff   [DEPTH];
  logic          ent_drop  [DEPTH];

  logic          nxt_valid [DEPTH];
  logic [7:0]    nxt_zone  [DEPTH];
  logic [1:0]    nxt_prio  [DEPTH];
  logic [AW-1:0] nxt_age   [DEPTH];
  logic          nxt_boost [DEPTH];

  logic          found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cnt;

  // Entries stay compacted oldest-first, so slot 0 tells emptiness and the last slot fullness.
  assign valid = ent_valid[0];
  assign full  = ent_valid[DEPTH-1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_eff[i] = ent_boost[i] ? 2'd3 : ent_prio[i];
    end
  end

  // Strict greater-than keeps the oldest entry on an effective-priority tie.
  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    win_eff   = '0;
    win_zone  = '0;
    win_boost = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (!found || ent_eff[i] > win_eff)) begin
        found     = 1'b1;
        win_idx   = IW'(i);
        win_eff   = ent_eff[i];
        win_zone  = ent_zone[i];
        win_boost = ent_boost[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_drop[i] = (serve_win && found && win_idx == IW'(i)) ||
                    (cancel && ent_valid[i] && ent_zone[i] == cancel_zone);
    end
  end

  // Survivors shift down and age; the new request lands in the first free slot after compaction.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_valid[i] = 1'b0;
      nxt_zone[i]  = '0;
      nxt_prio[i]  = '0;
      nxt_age[i]   = '0;
      nxt_boost[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && !ent_drop[i]) begin
        nxt_valid[cnt[IW-1:0]] = 1'b1;
        nxt_zone[cnt[IW-1:0]]  = ent_zone[i];
        nxt_prio[cnt[IW-1:0]]  = ent_prio[i];
        nxt_age[cnt[IW-1:0]]   = (ent_age[i] == AW'(AGE_MAX)) ? ent_age[i] : ent_age[i] + 1'b1;
        nxt_boost[cnt[IW-1:0]] = ent_boost[i] || (nxt_age[cnt[IW-1:0]] == AW'(AGE_MAX));
        cnt = cnt + 1'b1;
      end
    end
    if (push && cnt < (IW+1)'(DEPTH)) begin
      nxt_valid[cnt[IW-1:0]] = 1'b1;
      nxt_zone[cnt[IW-1:0]]  = push_zone;
      nxt_prio[cnt[IW-1:0]]  = push_prio;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_zone[i]  <= '0;
        ent_prio[i]  <= '0;
        ent_age[i]   <= '0;
        ent_boost[i] <= 1'b0;
      end
    end else begin
      ent_valid <= nxt_valid;
      ent_zone  <= nxt_zone;
      ent_prio  <= nxt_prio;
      ent_age   <= nxt_age;
      ent_boost <= nxt_boost;
    end
  end
endmodule

module main_gate #(
  parameter int DEPTH   = 4,
  parameter int AGE_MAX = 15
) (
  input  logic       Clock,
  input  logic       Reset_Queue,
  input  logic       Insert,
  input  logic       Serve,
  input  logic [7:0] Zone,
  input  logic [1:0] Priority,
  input  logic [1:0] Resource_line,
  output logic       Food_00,
  output logic       Shelter_01,
  output logic       Evacuation_10,
  output logic       Shelter_Full,
  output logic       Food_Full,
  output logic       Evac_Empty,
  output logic       Shelter_Valid,
  output logic       Shelter_Boost,
  output logic       Food_Valid,
  output logic       Food_Boost,
  output logic [7:0] Output_Zone,
  output logic [1:0] Output_Priority
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    evac_zone [DEPTH];
  logic [1:0]    evac_prio [DEPTH];
  logic [IW-1:0] head, tail;
  logic [IW:0]   count;

  logic       evac_ins, evac_push, evac_pop, has_evac;
  logic [7:0] s_zone, f_zone;
  logic [1:0] s_eff, f_eff;
  logic       sel_shelter, sel_food;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign has_evac   = (count != '0);
  assign Evac_Empty = !has_evac;
  assign evac_ins   = Insert && (Resource_line == 2'b10);
  assign evac_pop   = Serve && has_evac;
  assign evac_push  = evac_ins && ((count != (IW+1)'(DEPTH)) || evac_pop);

  // Shelter beats Food on equal effective priority; Evac beats both whenever it holds anything.
  assign sel_shelter = !has_evac && Shelter_Valid && (!Food_Valid || s_eff >= f_eff);
  assign sel_food    = !has_evac && Food_Valid && !sel_shelter;

  main_gate_pq #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) u_shelter (
    .clk(Clock), .rst_n(Reset_Queue),
    .serve_win(Serve && sel_shelter),
    .cancel(evac_ins), .cancel_zone(Zone),
    .push(Insert && (Resource_line == 2'b01)), .push_zone(Zone), .push_prio(Priority),
    .valid(Shelter_Valid), .full(Shelter_Full),
    .win_zone(s_zone), .win_eff(s_eff), .win_boost(Shelter_Boost)
  );

  main_gate_pq #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) u_food (
    .clk(Clock), .rst_n(Reset_Queue),
    .serve_win(Serve && sel_food),
    .cancel(evac_ins), .cancel_zone(Zone),
    .push(Insert && (Resource_line == 2'b00)), .push_zone(Zone), .push_prio(Priority),
    .valid(Food_Valid), .full(Food_Full),
    .win_zone(f_zone), .win_eff(f_eff), .win_boost(Food_Boost)
  );

  always_comb begin
    Evacuation_10   = 1'b0;
    Shelter_01      = 1'b0;
    Food_00         = 1'b0;
    Output_Zone     = '0;
    Output_Priority = '0;
    if (has_evac) begin
      Evacuation_10   = 1'b1;
      Output_Zone     = evac_zone[head];
      Output_Priority = evac_prio[head];
    end else if (sel_shelter) begin
      Shelter_01      = 1'b1;
      Output_Zone     = s_zone;
      Output_Priority = s_eff;
    end else if (sel_food) begin
      Food_00         = 1'b1;
      Output_Zone     = f_zone;
      Output_Priority = f_eff;
    end
  end

  always_ff @(posedge Clock or negedge Reset_Queue) begin
    if (!Reset_Queue) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        evac_zone[i] <= '0;
        evac_prio[i] <= '0;
      end
    end else begin
      if (evac_push) begin
        evac_zone[tail] <= Zone;
        evac_prio[tail] <= Priority;
        tail            <= wrap_inc(tail);
      end
      if (evac_pop) begin
        head <= wrap_inc(head);
      end
      case ({evac_push, evac_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_main_gate.sv
// Directed scoreboard bench for main_gate: each step queues its expected outputs,
// and the entry is popped and checked one time unit after the clock edge.

module tb_main_gate;
  localparam logic [1:0] RL_FOOD    = 2'b00;
  localparam logic [1:0] RL_SHELTER = 2'b01;
  localparam logic [1:0] RL_EVAC    = 2'b10;
  localparam logic [1:0] RL_NONE    = 2'b11;
  localparam logic [2:0] SEL_E = 3'b100;
  localparam logic [2:0] SEL_S = 3'b010;
  localparam logic [2:0] SEL_F = 3'b001;
  localparam logic [2:0] SEL_N = 3'b000;

  logic       Clock = 1'b0;
  logic       Reset_Queue = 1'b0;
  logic       Insert = 1'b0;
  logic       Serve = 1'b0;
  logic [7:0] Zone = '0;
  logic [1:0] Priority = '0;
  logic [1:0] Resource_line = '0;
  logic       Food_00, Shelter_01, Evacuation_10;
  logic       Shelter_Full, Food_Full, Evac_Empty;
  logic       Shelter_Valid, Shelter_Boost, Food_Valid, Food_Boost;
  logic [7:0] Output_Zone;
  logic [1:0] Output_Priority;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] zone;
    logic [1:0] prio;
    logic       sf, ff, ee, sv, sb, fv, fb;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  main_gate dut (
    .Clock(Clock), .Reset_Queue(Reset_Queue), .Insert(Insert), .Serve(Serve),
    .Zone(Zone), .Priority(Priority), .Resource_line(Resource_line),
    .Food_00(Food_00), .Shelter_01(Shelter_01), .Evacuation_10(Evacuation_10),
    .Shelter_Full(Shelter_Full), .Food_Full(Food_Full), .Evac_Empty(Evac_Empty),
    .Shelter_Valid(Shelter_Valid), .Shelter_Boost(Shelter_Boost),
    .Food_Valid(Food_Valid), .Food_Boost(Food_Boost),
    .Output_Zone(Output_Zone), .Output_Priority(Output_Priority)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] timeout");
  end

  function automatic exp_t mk(input string tag, input logic [2:0] sel, input logic [7:0] zone,
                              input logic [1:0] prio, input logic sf, input logic ff, input logic ee,
                              input logic sv, input logic sb, input logic fv, input logic fb);
    exp_t e;
    e.tag = tag; e.sel = sel; e.zone = zone; e.prio = prio;
    e.sf = sf; e.ff = ff; e.ee = ee; e.sv = sv; e.sb = sb; e.fv = fv; e.fb = fb;
    return e;
  endfunction

  function automatic exp_t idle_exp(input string tag);
    return mk(tag, SEL_N, 8'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard underflow observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    cmp({e.tag, "/sel"},   8'({Evacuation_10, Shelter_01, Food_00}), 8'(e.sel));
    cmp({e.tag, "/zone"},  Output_Zone, e.zone);
    cmp({e.tag, "/prio"},  8'(Output_Priority), 8'(e.prio));
    cmp({e.tag, "/sfull"}, 8'(Shelter_Full), 8'(e.sf));
    cmp({e.tag, "/ffull"}, 8'(Food_Full), 8'(e.ff));
    cmp({e.tag, "/eempty"}, 8'(Evac_Empty), 8'(e.ee));
    cmp({e.tag, "/svalid"}, 8'(Shelter_Valid), 8'(e.sv));
    cmp({e.tag, "/sboost"}, 8'(Shelter_Boost), 8'(e.sb));
    cmp({e.tag, "/fvalid"}, 8'(Food_Valid), 8'(e.fv));
    cmp({e.tag, "/fboost"}, 8'(Food_Boost), 8'(e.fb));
  endtask

  task automatic apply_stimulus(input logic ins, input logic srv, input logic [7:0] z,
                                input logic [1:0] p, input logic [1:0] rl, input exp_t e);
    Insert = ins; Serve = srv; Zone = z; Priority = p; Resource_line = rl;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
    Insert = 1'b0;
    Serve  = 1'b0;
    check_output();
  endtask

  initial begin
    #12;
    exp_q.push_back(idle_exp("reset_held"));
    check_output();
    Reset_Queue = 1'b1;
    @(posedge Clock);
    #1;
    exp_q.push_back(idle_exp("reset_released"));
    check_output();

    // Cross-queue selection and Evac cancellation of the same zone
    apply_stimulus(1, 0, 8'd12, 2'd1, RL_SHELTER, mk("s12", SEL_S, 8'd12, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd12, 2'd2, RL_FOOD,    mk("f12", SEL_F, 8'd12, 2'd2, 0,0,1,1,0,1,0));
    apply_stimulus(1, 0, 8'd12, 2'd1, RL_EVAC,    mk("e12", SEL_E, 8'd12, 2'd1, 0,0,0,0,0,0,0));
    apply_stimulus(0, 1, 8'd0,  2'd0, RL_NONE,    idle_exp("serve_e12"));

    apply_stimulus(1, 0, 8'd240, 2'd1, RL_SHELTER, mk("s240", SEL_S, 8'd240, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd15,  2'd2, RL_FOOD,    mk("f15",  SEL_F, 8'd15,  2'd2, 0,0,1,1,0,1,0));
    apply_stimulus(0, 1, 8'd0,   2'd0, RL_NONE,    mk("serve_f15", SEL_S, 8'd240, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(0, 1, 8'd0,   2'd0, RL_NONE,    idle_exp("serve_s240"));

    // Shelter fill, drop when full, insert+serve on full, oldest-first ties
    apply_stimulus(1, 0, 8'd1, 2'd1, RL_SHELTER, mk("fill1", SEL_S, 8'd1, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd2, 2'd1, RL_SHELTER, mk("fill2", SEL_S, 8'd1, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd3, 2'd2, RL_SHELTER, mk("fill3", SEL_S, 8'd3, 2'd2, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd4, 2'd0, RL_SHELTER, mk("fill4", SEL_S, 8'd3, 2'd2, 1,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd9, 2'd3, RL_SHELTER, mk("drop5", SEL_S, 8'd3, 2'd2, 1,0,1,1,0,0,0));
    apply_stimulus(1, 1, 8'd9, 2'd3, RL_SHELTER, mk("ins_srv", SEL_S, 8'd9, 2'd3, 1,0,1,1,0,0,0));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE,    mk("tie_old", SEL_S, 8'd1, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE,    mk("tie_next", SEL_S, 8'd2, 2'd1, 0,0,1,1,0,0,0));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE,    mk("last_s", SEL_S, 8'd4, 2'd0, 0,0,1,1,0,0,0));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE,    idle_exp("drain_s"));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE,    idle_exp("serve_empty"));
    apply_stimulus(1, 0, 8'd7, 2'd2, RL_NONE,    idle_exp("rl11"));

    // Evac FIFO order
    apply_stimulus(1, 0, 8'd20, 2'd2, RL_EVAC, mk("e20", SEL_E, 8'd20, 2'd2, 0,0,0,0,0,0,0));
    apply_stimulus(1, 0, 8'd21, 2'd0, RL_EVAC, mk("e21", SEL_E, 8'd20, 2'd2, 0,0,0,0,0,0,0));
    apply_stimulus(0, 1, 8'd0,  2'd0, RL_NONE, mk("pop20", SEL_E, 8'd21, 2'd0, 0,0,0,0,0,0,0));
    apply_stimulus(0, 1, 8'd0,  2'd0, RL_NONE, idle_exp("pop21"));

    // Cancellation still happens while Evac is full
    apply_stimulus(1, 0, 8'd30, 2'd1, RL_SHELTER, mk("s30", SEL_S, 8'd30, 2'd1, 0,0,1,1,0,0,0));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 8'(31 + i), 2'd3, RL_EVAC, mk("evfill", SEL_E, 8'd31, 2'd3, 0,0,0,1,0,0,0));
    end
    apply_stimulus(1, 0, 8'd30, 2'd0, RL_EVAC, mk("cancel_full", SEL_E, 8'd31, 2'd3, 0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, mk("evdrain", SEL_E, 8'(32 + i), 2'd3, 0,0,0,0,0,0,0));
    end
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, idle_exp("evdrain_last"));

    // Food fill and drain
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 8'(50 + i), 2'd1, RL_FOOD,
                     mk("ffill", SEL_F, 8'd50, 2'd1, 0, (i == 3), 1, 0, 0, 1, 0));
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, mk("fdrain", SEL_F, 8'(51 + i), 2'd1, 0,0,1,0,0,1,0));
    end
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, idle_exp("fdrain_last"));

    // Aging: Shelter zone 5 boosts on the 15th edge after its insert
    apply_stimulus(1, 0, 8'd5, 2'd0, RL_SHELTER, mk("s5", SEL_S, 8'd5, 2'd0, 0,0,1,1,0,0,0));
    apply_stimulus(1, 0, 8'd6, 2'd2, RL_FOOD,    mk("f6", SEL_F, 8'd6, 2'd2, 0,0,1,1,0,1,0));
    repeat (12) @(posedge Clock);
    #1;
    apply_stimulus(0, 0, 8'd0, 2'd0, RL_NONE, mk("age14", SEL_F, 8'd6, 2'd2, 0,0,1,1,0,1,0));
    apply_stimulus(0, 0, 8'd0, 2'd0, RL_NONE, mk("age15", SEL_S, 8'd5, 2'd3, 0,0,1,1,1,1,0));
    apply_stimulus(0, 0, 8'd0, 2'd0, RL_NONE, mk("both_boost", SEL_S, 8'd5, 2'd3, 0,0,1,1,1,1,1));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, mk("serve_s5", SEL_F, 8'd6, 2'd3, 0,0,1,0,0,1,1));
    apply_stimulus(0, 1, 8'd0, 2'd0, RL_NONE, idle_exp("serve_f6"));

    // Asynchronous reset mid-operation discards the in-flight insert
    apply_stimulus(1, 0, 8'd41, 2'd2, RL_EVAC, mk("e41", SEL_E, 8'd41, 2'd2, 0,0,0,0,0,0,0));
    Insert = 1'b1; Zone = 8'd40; Priority = 2'd1; Resource_line = RL_EVAC;
    #2;
    Reset_Queue = 1'b0;
    #1;
    exp_q.push_back(idle_exp("async_reset"));
    check_output();
    @(posedge Clock);
    #1;
    Insert = 1'b0;
    @(negedge Clock);
    Reset_Queue = 1'b1;
    @(posedge Clock);
    #1;
    exp_q.push_back(idle_exp("after_reset"));
    check_output();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
